// File: rtl/adder_rr_scheduler_if.sv
// ---------------------------------------------------------------------------
// adder_rr_scheduler_if
//
// Bundles every non-clock signal of adder_rr_scheduler.
//   Requester side : req, req_a, req_b, req_cin (in), gnt (out)
//   Adder side     : add_a, add_b, add_cin (out), add_s, add_cout (in)
//   Consumer side  : rsp_valid, rsp_id, rsp_s, rsp_cout (out), rsp_ready (in)
// Operand lanes are packed: requester i owns bits [i*n +: n] of req_a/req_b.
//
// Modports:
//   slave  - the scheduler itself
//   master - the environment (requesters, adder instance, response consumer)
// ---------------------------------------------------------------------------
interface adder_rr_scheduler_if #(
    parameter int n    = 64,
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req;
    logic [NREQ*n-1:0] req_a;
    logic [NREQ*n-1:0] req_b;
    logic [NREQ-1:0]   req_cin;
    logic [NREQ-1:0]   gnt;

    logic [n-1:0]      add_a;
    logic [n-1:0]      add_b;
    logic              add_cin;
    logic [n-1:0]      add_s;
    logic              add_cout;

    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [n-1:0]      rsp_s;
    logic              rsp_cout;
    logic              rsp_ready;

    modport slave (
        input  req, req_a, req_b, req_cin,
        output gnt,
        output add_a, add_b, add_cin,
        input  add_s, add_cout,
        output rsp_valid, rsp_id, rsp_s, rsp_cout,
        input  rsp_ready
    );

    modport master (
        output req, req_a, req_b, req_cin,
        input  gnt,
        input  add_a, add_b, add_cin,
        output add_s, add_cout,
        input  rsp_valid, rsp_id, rsp_s, rsp_cout,
        output rsp_ready
    );
endinterface

// File: rtl/adder_rr_scheduler.sv
// ---------------------------------------------------------------------------
// adder_rr_scheduler
//
// Shares one external combinational n-bit adder among NREQ requesters.
// A round-robin arbiter picks one requester per cycle; on the same edge the
// one-hot grant is registered and the winner's operands, carry-in and index
// are captured into the issue stage, which drives the adder directly. On the
// following edge the adder result is captured into the response stage
// together with the requester index.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - adder_rr_scheduler_if.slave (requests/grant, adder link, response)
//
// While a response is held (rsp_valid & ~rsp_ready) the scheduler is in STALL:
// no grant is issued and both stages hold their contents.
// ---------------------------------------------------------------------------
module adder_rr_scheduler #(
    parameter int n    = 64,
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    adder_rr_scheduler_if.slave bus
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } mode_e;

    mode_e           mode;

    // Arbiter result
    logic            win_found;
    logic [NREQ-1:0] win_oh;
    logic [IDW-1:0]  win_id;
    logic [IDW-1:0]  win_next;
    logic [n-1:0]    win_a;
    logic [n-1:0]    win_b;
    logic            win_cin;

    // Grant and round-robin pointer
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IDW-1:0]  ptr_q, ptr_d;

    // Issue stage
    logic            iss_valid_q, iss_valid_d;
    logic [IDW-1:0]  iss_id_q, iss_id_d;
    logic [n-1:0]    iss_a_q, iss_a_d;
    logic [n-1:0]    iss_b_q, iss_b_d;
    logic            iss_cin_q, iss_cin_d;

    // Response stage
    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [n-1:0]    rsp_s_q, rsp_s_d;
    logic            rsp_cout_q, rsp_cout_d;

    assign mode = (rsp_valid_q && !bus.rsp_ready) ? STALL : RUN;

    // Round-robin search: distance i from the pointer, requester j. Only one j
    // sits at each distance, so the first hit over increasing i is the winner.
    // Every index is a loop constant, which keeps the operand mux a plain
    // priority select.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch;
        // a path that skips an assignment would otherwise infer a latch.
        win_found = 1'b0;
        win_oh    = '0;
        win_id    = '0;
        win_next  = '0;
        win_a     = '0;
        win_b     = '0;
        win_cin   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!win_found && bus.req[j] &&
                    ((int'(ptr_q) + i == j) || (int'(ptr_q) + i == j + NREQ))) begin
                    win_found = 1'b1;
                    win_oh[j] = 1'b1;
                    win_id    = IDW'(j);
                    win_next  = IDW'((j + 1) % NREQ);
                    win_a     = bus.req_a[j*n +: n];
                    win_b     = bus.req_b[j*n +: n];
                    win_cin   = bus.req_cin[j];
                end
            end
        end
    end

    always_comb begin
        gnt_d       = '0;
        ptr_d       = ptr_q;
        iss_valid_d = iss_valid_q;
        iss_id_d    = iss_id_q;
        iss_a_d     = iss_a_q;
        iss_b_d     = iss_b_q;
        iss_cin_d   = iss_cin_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_s_d     = rsp_s_q;
        rsp_cout_d  = rsp_cout_q;

        if (mode == RUN) begin
            // Response stage: take the adder result of the op in the issue
            // stage. Data is left alone when the issue stage is empty.
            rsp_valid_d = iss_valid_q;
            if (iss_valid_q) begin
                rsp_id_d   = iss_id_q;
                rsp_s_d    = bus.add_s;
                rsp_cout_d = bus.add_cout;
            end

            // Issue stage: operands are sampled on the grant edge. With no
            // request the stage empties but keeps driving the last operands.
            iss_valid_d = win_found;
            if (win_found) begin
                gnt_d     = win_oh;
                ptr_d     = win_next;
                iss_id_d  = win_id;
                iss_a_d   = win_a;
                iss_b_d   = win_b;
                iss_cin_d = win_cin;
            end
        end
    end

    // NOTE: the operand and result registers are reset too, not only the
    // valid bits, so the adder inputs and response bus read zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q       <= '0;
            ptr_q       <= '0;
            iss_valid_q <= 1'b0;
            iss_id_q    <= '0;
            iss_a_q     <= '0;
            iss_b_q     <= '0;
            iss_cin_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_s_q     <= '0;
            rsp_cout_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of the others, independent of statement order.
            gnt_q       <= gnt_d;
            ptr_q       <= ptr_d;
            iss_valid_q <= iss_valid_d;
            iss_id_q    <= iss_id_d;
            iss_a_q     <= iss_a_d;
            iss_b_q     <= iss_b_d;
            iss_cin_q   <= iss_cin_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_s_q     <= rsp_s_d;
            rsp_cout_q  <= rsp_cout_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.add_a     = iss_a_q;
    assign bus.add_b     = iss_b_q;
    assign bus.add_cin   = iss_cin_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_s     = rsp_s_q;
    assign bus.rsp_cout  = rsp_cout_q;

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_adder_rr_scheduler
//
// Requesters are modelled as "pending operation" slots. A transaction-level
// model predicts, per clock, which slot is granted (first pending slot at or
// after the round-robin pointer), and which sum a+b+cin leaves the response
// register, honouring the rsp_ready backpressure. Inputs are driven and
// outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_adder_rr_scheduler;

    localparam int n        = 64;
    localparam int NREQ     = 4;
    localparam int IDW      = 2;
    localparam int RAND_OPS = 30000;
    localparam int RAND_MAX_CYC = 70000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    adder_rr_scheduler_if #(.n(n), .NREQ(NREQ), .IDW(IDW)) bus ();

    adder_rr_scheduler #(.n(n), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Stand-in for the shared combinational adder.
    assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b}
                                     + {{n{1'b0}}, bus.add_cin};

    // Requester slots
    logic         pend [NREQ];
    logic [n-1:0] op_a [NREQ];
    logic [n-1:0] op_b [NREQ];
    logic         op_c [NREQ];

    // Reference model
    logic [NREQ-1:0] m_gnt;
    int              m_ptr;
    logic            m_iss_v;
    int              m_iss_id;
    logic [n:0]      m_iss_sum;
    logic            m_rsp_v;
    int              m_rsp_id;
    logic [n:0]      m_rsp_sum;
    int              grants;

    logic [NREQ+IDW+3*n+2:0] out_vec;

    function automatic logic [n-1:0] rand_word();
        logic [n-1:0] w;
        case ($urandom_range(0, 5))
            0:       w = '0;
            1:       w = '1;
            default: w = {$urandom(), $urandom()};
        endcase
        return w;
    endfunction

    task automatic new_op(input int k);
        pend[k] = 1'b1;
        op_a[k] = rand_word();
        op_b[k] = rand_word();
        op_c[k] = 1'($urandom_range(0, 1));
    endtask

    task automatic clear_pend();
        for (int k = 0; k < NREQ; k++) pend[k] = 1'b0;
    endtask

    task automatic drive_bus();
        for (int k = 0; k < NREQ; k++) begin
            bus.req[k]           = pend[k];
            bus.req_a[k*n +: n]  = op_a[k];
            bus.req_b[k*n +: n]  = op_b[k];
            bus.req_cin[k]       = op_c[k];
        end
    endtask

    task automatic model_reset();
        m_gnt   = '0;
        m_ptr   = 0;
        m_iss_v = 1'b0;
        m_rsp_v = 1'b0;
    endtask

    // What one rising edge does, given the inputs presented before it.
    task automatic model_edge(input logic ready);
        if (m_rsp_v && !ready) begin
            m_gnt = '0;
            return;
        end
        m_rsp_v = m_iss_v;
        if (m_iss_v) begin
            m_rsp_id  = m_iss_id;
            m_rsp_sum = m_iss_sum;
        end
        m_gnt   = '0;
        m_iss_v = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            int k;
            k = (m_ptr + i) % NREQ;
            if (pend[k]) begin
                m_gnt[k]  = 1'b1;
                m_iss_v   = 1'b1;
                m_iss_id  = k;
                m_iss_sum = {1'b0, op_a[k]} + {1'b0, op_b[k]} + (n+1)'(op_c[k]);
                m_ptr     = (k + 1) % NREQ;
                grants++;
                break;
            end
        end
    endtask

    // Drive, step one clock, land on the falling edge; granted slots retire.
    task automatic cycle(input logic ready);
        bus.rsp_ready = ready;
        drive_bus();
        model_edge(ready);
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NREQ; k++) if (m_gnt[k]) pend[k] = 1'b0;
    endtask

    task automatic refill_all();
        for (int k = 0; k < NREQ; k++) if (!pend[k]) new_op(k);
    endtask

    task automatic test_reset();
        for (int k = 0; k < NREQ; k++) begin
            pend[k] = 1'b0; op_a[k] = '0; op_b[k] = '0; op_c[k] = 1'b0;
        end
        bus.rsp_ready = 1'b1;
        drive_bus();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        out_vec = {bus.gnt, bus.rsp_valid, bus.rsp_id, bus.rsp_s, bus.rsp_cout,
                   bus.add_a, bus.add_b, bus.add_cin};
        total++;
        if (out_vec !== '0) begin
            bad++; $display("FAIL reset_outputs: got %h want 0", out_vec);
        end
        rst_n = 1'b1;
        model_reset();

        // Run a stream, then assert reset between clock edges.
        for (int c = 0; c < 3; c++) begin
            refill_all();
            cycle(1'b1);
        end
        #2 rst_n = 1'b0;
        #1;
        out_vec = {bus.gnt, bus.rsp_valid, bus.rsp_id, bus.rsp_s, bus.rsp_cout,
                   bus.add_a, bus.add_b, bus.add_cin};
        total++;
        if (out_vec !== '0) begin
            bad++; $display("FAIL midstream_reset_outputs: got %h want 0", out_vec);
        end
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;

        refill_all();
        cycle(1'b1);
        total++;
        if (bus.gnt !== 4'b0001) begin
            bad++; $display("FAIL post_reset_first_gnt: got %b want 0001", bus.gnt);
        end
        total++;
        if (bus.rsp_valid !== 1'b0) begin
            bad++; $display("FAIL post_reset_no_stale_rsp: got %b want 0", bus.rsp_valid);
        end
        refill_all();
        cycle(1'b1);
        total++;
        if (bus.gnt !== 4'b0010) begin
            bad++; $display("FAIL post_reset_second_gnt: got %b want 0010", bus.gnt);
        end
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 ||
            {bus.rsp_cout, bus.rsp_s} !== m_rsp_sum) begin
            bad++; $display("FAIL post_reset_first_rsp: got v=%b id=%0d sum=%h want v=1 id=0 sum=%h",
                            bus.rsp_valid, bus.rsp_id, {bus.rsp_cout, bus.rsp_s}, m_rsp_sum);
        end

        // Clean restart for the following tests.
        clear_pend();
        drive_bus();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 8; i++) begin
            refill_all();
            cycle(1'b1);
            total++;
            if (bus.gnt !== NREQ'(1) << (i % NREQ)) begin
                bad++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, bus.gnt, NREQ'(1) << (i % NREQ));
            end
            if (i >= 1) begin
                total++;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== IDW'((i - 1) % NREQ) ||
                    {bus.rsp_cout, bus.rsp_s} !== m_rsp_sum) begin
                    bad++; $display("FAIL rr_rsp[%0d]: got v=%b id=%0d sum=%h want v=1 id=%0d sum=%h",
                                    i, bus.rsp_valid, bus.rsp_id, {bus.rsp_cout, bus.rsp_s},
                                    (i - 1) % NREQ, m_rsp_sum);
                end
            end
        end
        clear_pend();
        cycle(1'b1);
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd3 || {bus.rsp_cout, bus.rsp_s} !== m_rsp_sum) begin
            bad++; $display("FAIL rr_last_rsp: got v=%b id=%0d sum=%h want v=1 id=3 sum=%h",
                            bus.rsp_valid, bus.rsp_id, {bus.rsp_cout, bus.rsp_s}, m_rsp_sum);
        end
    endtask

    task automatic test_wrap();
        new_op(0);
        new_op(3);
        cycle(1'b1);
        total++;
        if (bus.gnt !== 4'b0001) begin
            bad++; $display("FAIL wrap_first: got %b want 0001", bus.gnt);
        end
        cycle(1'b1);
        total++;
        if (bus.gnt !== 4'b1000) begin
            bad++; $display("FAIL wrap_second: got %b want 1000", bus.gnt);
        end
        clear_pend();
        repeat (2) cycle(1'b1);
    endtask

    task automatic test_single_op();
        pend[2] = 1'b1;
        op_a[2] = '1;
        op_b[2] = 64'd1;
        op_c[2] = 1'b0;
        cycle(1'b1);
        total++;
        if (bus.gnt !== 4'b0100 || bus.rsp_valid !== 1'b0) begin
            bad++; $display("FAIL single_grant: got gnt=%b v=%b want gnt=0100 v=0", bus.gnt, bus.rsp_valid);
        end
        total++;
        if (bus.add_a !== 64'hFFFF_FFFF_FFFF_FFFF || bus.add_b !== 64'd1 || bus.add_cin !== 1'b0) begin
            bad++; $display("FAIL single_adder_inputs: got a=%h b=%h cin=%b want a=ffffffffffffffff b=1 cin=0",
                            bus.add_a, bus.add_b, bus.add_cin);
        end
        cycle(1'b1);
        total++;
        if (bus.gnt !== 4'b0000) begin
            bad++; $display("FAIL single_gnt_one_cycle: got %b want 0000", bus.gnt);
        end
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || bus.rsp_s !== 64'd0 || bus.rsp_cout !== 1'b1) begin
            bad++; $display("FAIL single_rsp: got v=%b id=%0d s=%h cout=%b want v=1 id=2 s=0 cout=1",
                            bus.rsp_valid, bus.rsp_id, bus.rsp_s, bus.rsp_cout);
        end
        cycle(1'b1);
        total++;
        if (bus.rsp_valid !== 1'b0) begin
            bad++; $display("FAIL single_rsp_once: got v=%b want 0", bus.rsp_valid);
        end
    endtask

    task automatic test_backpressure();
        int         sv_id;
        logic [n:0] sv_sum;
        for (int i = 0; i < 2; i++) begin
            if (!pend[0]) new_op(0);
            if (!pend[1]) new_op(1);
            cycle(1'b1);
            total++;
            if (bus.gnt !== NREQ'(1) << i) begin
                bad++; $display("FAIL bp_fill_gnt[%0d]: got %b want %b", i, bus.gnt, NREQ'(1) << i);
            end
        end
        sv_id  = m_rsp_id;
        sv_sum = m_rsp_sum;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0);
            total++;
            if (bus.gnt !== '0 || bus.rsp_valid !== 1'b1 || bus.rsp_id !== IDW'(sv_id) ||
                {bus.rsp_cout, bus.rsp_s} !== sv_sum) begin
                bad++; $display("FAIL bp_frozen[%0d]: got gnt=%b v=%b id=%0d sum=%h want gnt=0 v=1 id=%0d sum=%h",
                                i, bus.gnt, bus.rsp_valid, bus.rsp_id, {bus.rsp_cout, bus.rsp_s}, sv_id, sv_sum);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (!pend[0]) new_op(0);
            if (!pend[1]) new_op(1);
            cycle(1'b1);
            total++;
            if (bus.gnt !== NREQ'(1) << (i % 2) || bus.rsp_valid !== 1'b1 ||
                bus.rsp_id !== IDW'((i + 1) % 2) || {bus.rsp_cout, bus.rsp_s} !== m_rsp_sum) begin
                bad++; $display("FAIL bp_resume[%0d]: got gnt=%b v=%b id=%0d sum=%h want gnt=%b v=1 id=%0d sum=%h",
                                i, bus.gnt, bus.rsp_valid, bus.rsp_id, {bus.rsp_cout, bus.rsp_s},
                                NREQ'(1) << (i % 2), (i + 1) % 2, m_rsp_sum);
            end
        end
        clear_pend();
        repeat (2) cycle(1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            if (!pend[1]) new_op(1);
            cycle(1'b1);
            total++;
            if (bus.gnt !== 4'b0010) begin
                bad++; $display("FAIL b2b_gnt[%0d]: got %b want 0010", i, bus.gnt);
            end
            if (i >= 1) begin
                total++;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || {bus.rsp_cout, bus.rsp_s} !== m_rsp_sum) begin
                    bad++; $display("FAIL b2b_rsp[%0d]: got v=%b id=%0d sum=%h want v=1 id=1 sum=%h",
                                    i, bus.rsp_valid, bus.rsp_id, {bus.rsp_cout, bus.rsp_s}, m_rsp_sum);
                end
            end
        end
        clear_pend();
        repeat (2) cycle(1'b1);
    endtask

    task automatic test_random();
        int start;
        int cyc;
        start = grants;
        cyc   = 0;
        while (grants - start < RAND_OPS && bad < 50) begin
            if (cyc >= RAND_MAX_CYC) begin
                total++;
                bad++; $display("FAIL random_timeout: got %0d ops want %0d", grants - start, RAND_OPS);
                break;
            end
            for (int k = 0; k < NREQ; k++) if (!pend[k] && $urandom_range(0, 1) == 1) new_op(k);
            cycle($urandom_range(0, 3) != 0);
            cyc++;
            total++;
            if (bus.gnt !== m_gnt) begin
                bad++; $display("FAIL random_gnt@%0d: got %b want %b", cyc, bus.gnt, m_gnt);
            end
            total++;
            if (bus.rsp_valid !== m_rsp_v) begin
                bad++; $display("FAIL random_rsp_valid@%0d: got %b want %b", cyc, bus.rsp_valid, m_rsp_v);
            end
            if (m_rsp_v) begin
                total++;
                if (bus.rsp_id !== IDW'(m_rsp_id) || {bus.rsp_cout, bus.rsp_s} !== m_rsp_sum) begin
                    bad++; $display("FAIL random_rsp@%0d: got id=%0d sum=%h want id=%0d sum=%h",
                                    cyc, bus.rsp_id, {bus.rsp_cout, bus.rsp_s}, m_rsp_id, m_rsp_sum);
                end
            end
        end
    endtask

    initial begin
        grants = 0;
        model_reset();
        test_reset();
        test_round_robin();
        test_wrap();
        test_single_op();
        test_backpressure();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
